apu_frame_sequencer: RTL and testbench

//  Frame-counter controller for the APU: a 15-bit up counter plus a sequencing FSM that issues

---
 rtl/apu_frame_sequencer.sv | 145 ++++++++++++++
 tb/tb_apu_frame_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: 15-bit frame counter with 4/5-step schedule,
// delayed restart after a $4017 write, quarter/half strobes and frame IRQ.
module apu_frame_sequencer #(
  parameter int unsigned STEP1    = 3728,
  parameter int unsigned STEP2    = 7456,
  parameter int unsigned STEP3    = 11185,
  parameter int unsigned STEP4    = 14914,
  parameter int unsigned STEP5    = 18640,
  parameter int unsigned WR_DELAY = 2
) (
  input  logic        CLK,
  input  logic        nRES,
  input  logic        aclk_en,
  input  logic        wr_en,
  input  logic        wr_mode,
  input  logic        wr_irq_inh,
  input  logic        irq_ack,
  output logic        qframe,
  output logic        hframe,
  output logic        frame_irq,
  output logic        mode,
  output logic [14:0] cnt
);

  localparam logic [14:0] S1  = 15'(STEP1);
  localparam logic [14:0] S2  = 15'(STEP2);
  localparam logic [14:0] S3  = 15'(STEP3);
  localparam logic [14:0] S4  = 15'(STEP4);
  localparam logic [14:0] S5  = 15'(STEP5);
  localparam logic [2:0]  DLY = 3'(WR_DELAY);

  typedef enum logic {RUN, PEND} state_t;

  state_t      state;
  state_t      state_n;
  logic [2:0]  delay;
  logic        inh;
  logic        run_mode;
  logic        restart;
  logic        at_end;
  logic [14:0] cnt_inc;
  logic        q_n;
  logic        h_n;
  logic        set_irq;
  logic        irq_n;

  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) state <= RUN;
    else       state <= state_n;
  end

  // A write during PEND reloads the delay, so it also wins over expiry.
  always_comb begin
    state_n = state;
    unique case (state)
      RUN:  if (wr_en) state_n = PEND;
      PEND: begin
        if (wr_en)
          state_n = PEND;
        else if (aclk_en && delay == 3'd1)
          state_n = RUN;
      end
      default: state_n = RUN;
    endcase
  end

  always_comb begin
    restart = (state == PEND) && aclk_en
           && !wr_en && (delay == 3'd1);
  end

  // run_mode is the schedule in force; mode switches it only at restart.
  always_comb begin
    at_end  = run_mode ? (cnt == S5) : (cnt == S4);
    cnt_inc = at_end ? 15'd0 : cnt + 15'd1;
  end

  always_comb begin
    q_n     = 1'b0;
    h_n     = 1'b0;
    set_irq = 1'b0;
    if (restart) begin
      q_n = mode;
      h_n = mode;
    end else if (aclk_en) begin
      unique case (1'b1)
        cnt_inc == S1: q_n = 1'b1;
        cnt_inc == S2: begin
          q_n = 1'b1;
          h_n = 1'b1;
        end
        cnt_inc == S3: q_n = 1'b1;
        cnt_inc == S4: begin
          q_n     = !run_mode;
          h_n     = !run_mode;
          set_irq = !run_mode && !inh;
        end
        cnt_inc == S5: begin
          q_n = run_mode;
          h_n = run_mode;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    irq_n = frame_irq;
    if (irq_ack)              irq_n = 1'b0;
    if (set_irq)              irq_n = 1'b1;
    if (wr_en && wr_irq_inh)  irq_n = 1'b0;
  end

  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      cnt       <= 15'd0;
      mode      <= 1'b0;
      run_mode  <= 1'b0;
      inh       <= 1'b0;
      frame_irq <= 1'b0;
      qframe    <= 1'b0;
      hframe    <= 1'b0;
      delay     <= 3'd0;
    end else begin
      qframe    <= q_n;
      hframe    <= h_n;
      frame_irq <= irq_n;
      if (restart) begin
        cnt      <= 15'd0;
        run_mode <= mode;
      end else if (aclk_en) begin
        cnt <= cnt_inc;
      end
      if (wr_en) begin
        mode  <= wr_mode;
        inh   <= wr_irq_inh;
        delay <= DLY;
      end else if (state == PEND && aclk_en
                   && delay != 3'd0) begin
        delay <= delay - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Bench for apu_frame_sequencer: expected strobe events are queued
// by the stimulus and popped by a monitor whenever a strobe appears.
module tb_apu_frame_sequencer;

  logic        CLK = 1'b0;
  logic        nRES = 1'b0;
  logic        aclk_en = 1'b0;
  logic        wr_en = 1'b0;
  logic        wr_mode = 1'b0;
  logic        wr_irq_inh = 1'b0;
  logic        irq_ack = 1'b0;
  logic        qframe;
  logic        hframe;
  logic        frame_irq;
  logic        mode;
  logic [14:0] cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [14:0] c;
    logic        q;
    logic        h;
    logic        i;
  } ev_t;

  ev_t exp_q[$];
  ev_t act_e;
  ev_t exp_e;

  always #5 CLK = ~CLK;

  apu_frame_sequencer #(
    .STEP1(3), .STEP2(7), .STEP3(11),
    .STEP4(15), .STEP5(19), .WR_DELAY(2)
  ) dut (
    .CLK(CLK),
    .nRES(nRES),
    .aclk_en(aclk_en),
    .wr_en(wr_en),
    .wr_mode(wr_mode),
    .wr_irq_inh(wr_irq_inh),
    .irq_ack(irq_ack),
    .qframe(qframe),
    .hframe(hframe),
    .frame_irq(frame_irq),
    .mode(mode),
    .cnt(cnt)
  );

  task automatic check(input string name, input int act,
                       input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  task automatic push(input int c, input logic q,
                      input logic h, input logic i);
    exp_q.push_back({15'(c), q, h, i});
  endtask

  task automatic cyc(input logic en);
    aclk_en = en;
    @(posedge CLK);
    @(negedge CLK);
    aclk_en    = 1'b0;
    wr_en      = 1'b0;
    wr_irq_inh = 1'b0;
    irq_ack    = 1'b0;
  endtask

  task automatic tick();
    cyc(1'b1);
    cyc(1'b0);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic set_wr(input logic m, input logic ih);
    wr_en      = 1'b1;
    wr_mode    = m;
    wr_irq_inh = ih;
  endtask

  always @(negedge CLK) begin
    if (nRES && (qframe || hframe)) begin
      act_e = {cnt, qframe, hframe, frame_irq};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe: unexpected cnt=%0d q=%0b h=%0b irq=%0b",
                 cnt, qframe, hframe, frame_irq);
      end else begin
        exp_e = exp_q.pop_front();
        if (act_e != exp_e) begin
          errors++;
          $display("FAIL strobe: got cnt=%0d q=%0b h=%0b irq=%0b, want cnt=%0d q=%0b h=%0b irq=%0b",
                   act_e.c, act_e.q, act_e.h, act_e.i,
                   exp_e.c, exp_e.q, exp_e.h, exp_e.i);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int hc;
    #1;
    check("reset cnt", cnt, 0);
    check("reset q", qframe, 0);
    check("reset h", hframe, 0);
    check("reset irq", frame_irq, 0);
    check("reset mode", mode, 0);
    @(negedge CLK);
    @(negedge CLK);
    nRES = 1'b1;

    // 4-step run from reset
    push(3, 1, 0, 0);  push(7, 1, 1, 0);
    push(11, 1, 0, 0); push(15, 1, 1, 1);
    push(3, 1, 0, 1);  push(7, 1, 1, 1);
    push(11, 1, 0, 1); push(15, 1, 1, 1);
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (i == 15) check("t2 cnt at 15", cnt, 15);
      if (i == 16) check("t2 wrap to 0", cnt, 0);
    end
    check("t2 cnt end", cnt, 0);
    check("t2 irq", frame_irq, 1);

    // asynchronous reset mid-count
    push(3, 1, 0, 1); push(7, 1, 1, 1);
    ticks(9);
    check("t1 cnt before", cnt, 9);
    #2 nRES = 1'b0;
    #1;
    check("t1 async cnt", cnt, 0);
    check("t1 async irq", frame_irq, 0);
    check("t1 async q", qframe, 0);
    check("t1 async h", hframe, 0);
    check("t1 async mode", mode, 0);
    @(negedge CLK);
    nRES = 1'b1;

    // ack and set on the same edge: set wins
    push(3, 1, 0, 0); push(7, 1, 1, 0); push(11, 1, 0, 0);
    ticks(14);
    irq_ack = 1'b1;
    push(15, 1, 1, 1);
    tick();
    check("t4 ack vs set", frame_irq, 1);
    tick();
    check("t4 wrap", cnt, 0);
    // inhibit write on the set edge: clear wins
    push(3, 1, 0, 1); push(7, 1, 1, 1); push(11, 1, 0, 1);
    ticks(14);
    set_wr(1'b0, 1'b1);
    push(15, 1, 1, 0);
    tick();
    check("t4 inh vs set", frame_irq, 0);
    ticks(2);
    check("t4 restart cnt", cnt, 0);
    // re-enable, set again, then a plain ack
    set_wr(1'b0, 1'b0);
    cyc(1'b0);
    ticks(2);
    check("t4 restart2 cnt", cnt, 0);
    push(3, 1, 0, 0); push(7, 1, 1, 0);
    push(11, 1, 0, 0); push(15, 1, 1, 1);
    ticks(15);
    check("t4 irq set", frame_irq, 1);
    irq_ack = 1'b1;
    cyc(1'b0);
    check("t4 ack clears", frame_irq, 0);
    tick();
    check("t4 cnt wrap", cnt, 0);

    // 5-step write at cnt=5
    push(3, 1, 0, 0);
    ticks(5);
    set_wr(1'b1, 1'b0);
    tick();
    check("t3 mode latched", mode, 1);
    check("t3 cnt keeps counting", cnt, 6);
    push(7, 1, 1, 0);
    tick();
    push(0, 1, 1, 0);
    tick();
    check("t3 restart cnt", cnt, 0);
    push(3, 1, 0, 0); push(7, 1, 1, 0);
    push(11, 1, 0, 0); push(19, 1, 1, 0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 15) check("t3 cnt 15", cnt, 15);
      if (i == 19) check("t3 cnt 19", cnt, 19);
    end
    check("t3 wrap", cnt, 0);
    check("t3 no irq", frame_irq, 0);

    // back-to-back writes, last one wins
    ticks(2);
    set_wr(1'b0, 1'b0);
    cyc(1'b0);
    push(3, 1, 0, 0);
    tick();
    set_wr(1'b1, 1'b0);
    cyc(1'b0);
    tick();
    check("t5 no early restart", cnt, 4);
    push(0, 1, 1, 0);
    tick();
    check("t5 restart cnt", cnt, 0);
    check("t5 mode", mode, 1);
    push(3, 1, 0, 0); push(7, 1, 1, 0);
    push(11, 1, 0, 0); push(19, 1, 1, 0);
    ticks(20);
    check("t5 wrap", cnt, 0);

    // stall at cnt=7
    push(3, 1, 0, 0);
    ticks(6);
    push(7, 1, 1, 0);
    cyc(1'b1);
    hc = int'(hframe);
    repeat (20) begin
      cyc(1'b0);
      hc += int'(hframe);
    end
    check("t6 h width", hc, 1);
    check("t6 cnt hold", cnt, 7);

    check("queue drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
